// File: rtl/dmem_sequencer.sv
// dmem_sequencer: multi-cycle data-memory access sequencer for the MIPS memory stage.
// Issues one handshaked bus transaction per load/store, stalls the pipeline until the
// transaction completes, performs big-endian lane steering, sign/zero extension and
// lwl/lwr/swl/swr merging, and flags misaligned accesses.
// Optional watchdog: define DMEM_SEQ_TIMEOUT_EN to add the TIMEOUT parameter and abort
// requests that see no mem_ack within TIMEOUT REQ cycles (reported on bus_err).
module dmem_sequencer
`ifdef DMEM_SEQ_TIMEOUT_EN
  #(parameter int TIMEOUT = 64)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  OPCODE,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] rt_val,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        addr_err,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [5:0] OP_LB  = 6'h20, OP_LH  = 6'h21, OP_LWL = 6'h22, OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24, OP_LHU = 6'h25, OP_LWR = 6'h26;
  localparam logic [5:0] OP_SB  = 6'h28, OP_SH  = 6'h29, OP_SWL = 6'h2A, OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SWR = 6'h2E;

  typedef enum logic [1:0] {IDLE, REQ, DONE} stateT;
  stateT stateReg, stateNext;

  logic [1:0]  k;
  logic [5:0]  opEff;
  logic        access, misaligned, issue, timeoutHit;
  logic [3:0]  issueBe;
  logic [31:0] issueWdata;

  logic        memReqReg, memWeReg, rdataValidReg, busErrReg;
  logic [31:0] memAddrReg, memWdataReg, rtReg, rdataReg;
  logic [3:0]  memBeReg;
  logic [5:0]  opReg;
  logic [1:0]  kReg;
  logic [31:0] wordShl, wordShr, loadFmt;

  assign k      = addr[1:0];
  assign access = MemRead | MemWrite;

  // Effective operation: writes win over reads, unknown opcodes fall back to lw/sw
  always_comb begin
    opEff = OP_LW;
    if (MemWrite) begin
      case (OPCODE)
        OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR: opEff = OPCODE;
        default:                             opEff = OP_SW;
      endcase
    end else begin
      case (OPCODE)
        OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR: opEff = OPCODE;
        default:                                             opEff = OP_LW;
      endcase
    end
  end

  // Alignment check and store lane steering for the access presented in IDLE
  always_comb begin
    misaligned = 1'b0;
    issueBe    = 4'hF;
    issueWdata = 32'h0;
    case (opEff)
      OP_LW:         misaligned = (k != 2'd0);
      OP_LH, OP_LHU: misaligned = k[0];
      OP_SW: begin
        misaligned = (k != 2'd0);
        issueWdata = rt_val;
      end
      OP_SH: begin
        misaligned = k[0];
        issueBe    = 4'b1100 >> k;
        issueWdata = {2{rt_val[15:0]}};
      end
      OP_SB: begin
        issueBe    = 4'b1000 >> k;
        issueWdata = {4{rt_val[7:0]}};
      end
      OP_SWL: begin
        issueBe    = 4'hF >> k;
        issueWdata = rt_val >> {k, 3'b000};
      end
      OP_SWR: begin
        issueBe    = 4'hF << ~k;
        issueWdata = rt_val << {~k, 3'b000};
      end
      default: ;
    endcase
  end

  assign issue = (stateReg == IDLE) && access && !misaligned;

`ifdef DMEM_SEQ_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] toCntReg;

  // Watchdog: counts cycles spent in REQ, cleared whenever the FSM is elsewhere
  always_ff @(posedge clk) begin
    if (rst || stateReg != REQ) toCntReg <= '0;
    else                        toCntReg <= toCntReg + CntW'(1);
  end

  assign timeoutHit = (stateReg == REQ) && !mem_ack && (toCntReg == CntW'(TIMEOUT - 1));
`else
  assign timeoutHit = 1'b0;
`endif

  // Load formatting from the returned word, offset and merge source captured at issue
  always_comb begin
    wordShl = mem_rdata << {kReg, 3'b000};
    wordShr = mem_rdata >> {~kReg, 3'b000};
    loadFmt = mem_rdata;
    case (opReg)
      OP_LB:   loadFmt = {{24{wordShl[31]}}, wordShl[31:24]};
      OP_LBU:  loadFmt = {24'h0, wordShl[31:24]};
      OP_LH:   loadFmt = {{16{wordShl[31]}}, wordShl[31:16]};
      OP_LHU:  loadFmt = {16'h0, wordShl[31:16]};
      OP_LWL:  loadFmt = wordShl | (rtReg & ~(32'hFFFF_FFFF << {kReg, 3'b000}));
      OP_LWR:  loadFmt = wordShr | (rtReg & ~(32'hFFFF_FFFF >> {~kReg, 3'b000}));
      default: loadFmt = mem_rdata;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) stateReg <= IDLE;
    else     stateReg <= stateNext;
  end

  // FSM next state and combinational pipeline-facing strobes
  always_comb begin
    stateNext = stateReg;
    stall     = 1'b0;
    addr_err  = 1'b0;
    case (stateReg)
      IDLE: begin
        if (issue) stateNext = REQ;
        stall    = !rst && issue;
        addr_err = !rst && access && misaligned;
      end
      REQ: begin
        stall = !rst;
        if (mem_ack || timeoutHit) stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Bus-side registers, captured load result and completion pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      memReqReg     <= 1'b0;
      memWeReg      <= 1'b0;
      memAddrReg    <= 32'h0;
      memBeReg      <= 4'h0;
      memWdataReg   <= 32'h0;
      opReg         <= 6'h0;
      kReg          <= 2'd0;
      rtReg         <= 32'h0;
      rdataReg      <= 32'h0;
      rdataValidReg <= 1'b0;
      busErrReg     <= 1'b0;
    end else begin
      rdataValidReg <= 1'b0;
      busErrReg     <= 1'b0;
      if (issue) begin
        memReqReg   <= 1'b1;
        memWeReg    <= MemWrite;
        memAddrReg  <= {addr[31:2], 2'b00};
        memBeReg    <= issueBe;
        memWdataReg <= MemWrite ? issueWdata : 32'h0;
        opReg       <= opEff;
        kReg        <= k;
        rtReg       <= rt_val;
      end else if (stateReg == REQ) begin
        if (mem_ack) begin
          memReqReg <= 1'b0;
          if (!memWeReg) begin
            rdataReg      <= loadFmt;
            rdataValidReg <= 1'b1;
          end
        end else if (timeoutHit) begin
          memReqReg <= 1'b0;
          busErrReg <= 1'b1;
        end
      end
    end
  end

  assign mem_req     = memReqReg;
  assign mem_we      = memWeReg;
  assign mem_addr    = memAddrReg;
  assign mem_be      = memBeReg;
  assign mem_wdata   = memWdataReg;
  assign rdata       = rdataReg;
  assign rdata_valid = rdataValidReg;
  assign bus_err     = busErrReg;

endmodule

// File: tb/tb_dmem_sequencer.sv
module tb_dmem_sequencer;

  localparam logic [5:0] OP_LB  = 6'h20, OP_LH  = 6'h21, OP_LWL = 6'h22, OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24, OP_LHU = 6'h25, OP_LWR = 6'h26;
  localparam logic [5:0] OP_SB  = 6'h28, OP_SH  = 6'h29, OP_SWL = 6'h2A, OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SWR = 6'h2E;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  OPCODE = 6'h0;
  logic        MemRead = 1'b0, MemWrite = 1'b0;
  logic [31:0] addr = 32'h0, rt_val = 32'h0;
  logic        stall, rdata_valid, addr_err, bus_err, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int checks = 0;
  int failures = 0;
  logic [31:0] memW [0:7];
  logic [31:0] lastRdata = 32'h0;

  always #5 clk = ~clk;

`ifdef DMEM_SEQ_TIMEOUT_EN
  dmem_sequencer #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .OPCODE(OPCODE), .MemRead(MemRead), .MemWrite(MemWrite),
    .addr(addr), .rt_val(rt_val), .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
    .addr_err(addr_err), .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );
`else
  dmem_sequencer dut (
    .clk(clk), .rst(rst), .OPCODE(OPCODE), .MemRead(MemRead), .MemWrite(MemWrite),
    .addr(addr), .rt_val(rt_val), .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
    .addr_err(addr_err), .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );
`endif

  // ---------------- reference model (byte lane 0 = bits 31:24) ----------------
  function automatic logic [7:0] byteOf(input logic [31:0] w, input int i);
    return w[31-8*i -: 8];
  endfunction

  function automatic logic [31:0] setByte(input logic [31:0] w, input int i, input logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[31-8*i -: 8] = b;
    return r;
  endfunction

  function automatic bit isStoreOp(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SWL) || (op == OP_SW) || (op == OP_SWR);
  endfunction

  function automatic logic [31:0] modelLoad(input logic [5:0] op, input int k,
                                            input logic [31:0] w, input logic [31:0] rt);
    logic [31:0] r;
    logic [7:0] b0, b1;
    r  = w;
    b0 = byteOf(w, k);
    b1 = byteOf(w, (k + 1) % 4);
    case (op)
      OP_LB:  r = {{24{b0[7]}}, b0};
      OP_LBU: r = {24'h0, b0};
      OP_LH:  r = {{16{b0[7]}}, b0, b1};
      OP_LHU: r = {16'h0, b0, b1};
      OP_LWL:
        for (int i = 0; i < 4; i++) begin
          if (i < 4 - k) r = setByte(r, i, byteOf(w, k + i));
          else           r = setByte(r, i, byteOf(rt, i));
        end
      OP_LWR:
        for (int i = 0; i < 4; i++) begin
          if (i >= 3 - k) r = setByte(r, i, byteOf(w, i - (3 - k)));
          else            r = setByte(r, i, byteOf(rt, i));
        end
      default: r = w;
    endcase
    return r;
  endfunction

  task automatic modelStore(input logic [5:0] op, input int k, input logic [31:0] rt,
                            output logic [3:0] be, output logic [31:0] wd);
    be = 4'h0;
    wd = 32'h0;
    case (op)
      OP_SB: begin
        be[3-k] = 1'b1;
        for (int i = 0; i < 4; i++) wd = setByte(wd, i, byteOf(rt, 3));
      end
      OP_SH: begin
        be[3-k] = 1'b1;
        be[2-k] = 1'b1;
        for (int i = 0; i < 4; i++) wd = setByte(wd, i, byteOf(rt, 2 + (i % 2)));
      end
      OP_SWL:
        for (int i = k; i < 4; i++) begin
          be[3-i] = 1'b1;
          wd = setByte(wd, i, byteOf(rt, i - k));
        end
      OP_SWR:
        for (int i = 0; i <= k; i++) begin
          be[3-i] = 1'b1;
          wd = setByte(wd, i, byteOf(rt, i + 3 - k));
        end
      default: begin
        be = 4'hF;
        wd = rt;
      end
    endcase
  endtask

  // One complete aligned transaction; waitCyc = REQ cycles before the acked one
  task automatic runOp(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rt,
                       input int waitCyc, output int stallCnt,
                       output logic [3:0] obsBe, output logic [31:0] obsWd);
    bit st;
    int k, idx;
    logic [3:0] eBe;
    logic [31:0] eWd, eRd;
    st  = isStoreOp(op);
    k   = int'(a[1:0]);
    idx = int'(a[4:2]);
    stallCnt = 0;
    obsBe = 4'h0;
    obsWd = 32'h0;
    modelStore(op, k, rt, eBe, eWd);
    eRd = st ? lastRdata : modelLoad(op, k, memW[idx], rt);

    @(negedge clk);
    OPCODE = op; MemRead = !st; MemWrite = st; addr = a; rt_val = rt;
    mem_ack = 1'($urandom_range(0, 1));
    #1;
    if (stall === 1'b1) stallCnt++;
    checks++;
    if (stall !== 1'b1 || mem_req !== 1'b0 || rdata_valid !== 1'b0 || addr_err !== 1'b0)
      begin failures++; $display("FAIL issue op=%h: stall=%b req=%b rv=%b aerr=%b, need 1 0 0 0",
                                 op, stall, mem_req, rdata_valid, addr_err); end

    for (int c = 0; c <= waitCyc; c++) begin
      @(negedge clk);
      mem_ack   = (c == waitCyc);
      mem_rdata = st ? $urandom : memW[idx];
      #1;
      if (stall === 1'b1) stallCnt++;
      if (c == 0) begin obsBe = mem_be; obsWd = mem_wdata; end
      checks++;
      if (mem_req !== 1'b1 || stall !== 1'b1 || rdata_valid !== 1'b0)
        begin failures++; $display("FAIL req_cycle%0d: req=%b stall=%b rv=%b, need 1 1 0",
                                   c, mem_req, stall, rdata_valid); end
      checks++;
      if (mem_addr !== {a[31:2], 2'b00} || mem_we !== st)
        begin failures++; $display("FAIL bus_addr: addr=%h we=%b, need %h %b",
                                   mem_addr, mem_we, {a[31:2], 2'b00}, st); end
      if (st) begin
        checks++;
        if (mem_be !== eBe || mem_wdata !== eWd)
          begin failures++; $display("FAIL store_lanes op=%h: be=%b wdata=%h, need %b %h",
                                     op, mem_be, mem_wdata, eBe, eWd); end
      end
    end

    @(negedge clk);
    mem_ack = 1'($urandom_range(0, 1));
    #1;
    if (stall === 1'b1) stallCnt++;
    checks++;
    if (stall !== 1'b0 || mem_req !== 1'b0 || rdata_valid !== !st || rdata !== eRd)
      begin failures++; $display("FAIL done op=%h: stall=%b req=%b rv=%b rdata=%h, need 0 0 %b %h",
                                 op, stall, mem_req, rdata_valid, rdata, !st, eRd); end
    if (st) begin
      for (int i = 0; i < 4; i++)
        if (eBe[3-i]) memW[idx] = setByte(memW[idx], i, byteOf(eWd, i));
    end else lastRdata = eRd;
    $display("txn op=%h addr=%h rt=%h wait=%0d rdata=%h be=%b wdata=%h",
             op, a, rt, waitCyc, rdata, obsBe, obsWd);
  endtask

  task automatic idleCycle();
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0; mem_ack = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || rdata_valid !== 1'b0 || stall !== 1'b0)
      begin failures++; $display("FAIL idle: req=%b rv=%b stall=%b, need 0 0 0",
                                 mem_req, rdata_valid, stall); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; OPCODE = OP_LW; MemRead = 1'b1; addr = 32'h100;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (stall !== 1'b0 || mem_req !== 1'b0 || rdata_valid !== 1'b0 || addr_err !== 1'b0 ||
        bus_err !== 1'b0 || mem_we !== 1'b0)
      begin failures++; $display("FAIL reset_ctrl: stall=%b req=%b rv=%b aerr=%b berr=%b we=%b, need all 0",
                                 stall, mem_req, rdata_valid, addr_err, bus_err, mem_we); end
    checks++;
    if (rdata !== 32'h0 || mem_addr !== 32'h0 || mem_be !== 4'h0 || mem_wdata !== 32'h0)
      begin failures++; $display("FAIL reset_data: rdata=%h addr=%h be=%b wdata=%h, need all 0",
                                 rdata, mem_addr, mem_be, mem_wdata); end
    MemRead = 1'b0;
    rst = 1'b0;
    lastRdata = 32'h0;
    idleCycle();
  endtask

  task automatic test_directed();
    int sc;
    logic [3:0] be;
    logic [31:0] wd;
    memW[0] = 32'h8899AABB;
    runOp(OP_LB, 32'h101, 32'h0, 0, sc, be, wd);
    checks++;
    if (rdata !== 32'hFFFFFF99 || sc != 2)
      begin failures++; $display("FAIL lb_0x101: rdata=%h stall_cycles=%0d, need ffffff99 2", rdata, sc); end
    runOp(OP_LWL, 32'h102, 32'h11223344, 0, sc, be, wd);
    checks++;
    if (rdata !== 32'hAABB3344)
      begin failures++; $display("FAIL lwl_0x102: rdata=%h, need aabb3344", rdata); end
    runOp(OP_LWR, 32'h101, 32'h11223344, 0, sc, be, wd);
    checks++;
    if (rdata !== 32'h11228899)
      begin failures++; $display("FAIL lwr_0x101: rdata=%h, need 11228899", rdata); end
    runOp(OP_SH, 32'h102, 32'h0000CAFE, 0, sc, be, wd);
    checks++;
    if (be !== 4'b0011 || wd !== 32'hCAFECAFE || rdata !== 32'h11228899)
      begin failures++; $display("FAIL sh_0x102: be=%b wdata=%h rdata=%h, need 0011 cafecafe 11228899",
                                 be, wd, rdata); end
    runOp(OP_SWL, 32'h101, 32'hDEADBEEF, 0, sc, be, wd);
    checks++;
    if (be !== 4'b0111 || wd !== 32'h00DEADBE)
      begin failures++; $display("FAIL swl_0x101: be=%b wdata=%h, need 0111 00deadbe", be, wd); end
    idleCycle();
  endtask

  task automatic test_wait();
    int sc;
    logic [3:0] be;
    logic [31:0] wd;
    memW[1] = 32'h13579BDF;
    runOp(OP_LW, 32'h104, 32'h0, 4, sc, be, wd);
    checks++;
    if (sc != 6 || rdata !== 32'h13579BDF)
      begin failures++; $display("FAIL lw_wait: stall_cycles=%0d rdata=%h, need 6 13579bdf", sc, rdata); end
    idleCycle();
  endtask

  task automatic test_reset_mid_req();
    @(negedge clk);
    OPCODE = OP_LW; MemRead = 1'b1; MemWrite = 1'b0; addr = 32'h104; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b1)
      begin failures++; $display("FAIL rst_mid_pre: req=%b, need 1", mem_req); end
    rst = 1'b1; MemRead = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || rdata_valid !== 1'b0 || stall !== 1'b0 || rdata !== 32'h0)
      begin failures++; $display("FAIL rst_mid_post: req=%b rv=%b stall=%b rdata=%h, need 0 0 0 0",
                                 mem_req, rdata_valid, stall, rdata); end
    lastRdata = 32'h0;
    mem_ack = 1'b1;
    idleCycle();
    idleCycle();
  endtask

  task automatic test_misaligned();
    logic [5:0]  ops [4];
    logic [31:0] adrs [4];
    ops  = '{OP_LW, OP_SW, OP_LH, OP_SH};
    adrs = '{32'h106, 32'h101, 32'h103, 32'h105};
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      OPCODE = ops[t]; MemRead = !isStoreOp(ops[t]); MemWrite = isStoreOp(ops[t]);
      addr = adrs[t]; rt_val = $urandom;
      #1;
      checks++;
      if (addr_err !== 1'b1 || stall !== 1'b0 || mem_req !== 1'b0)
        begin failures++; $display("FAIL misalign op=%h addr=%h: aerr=%b stall=%b req=%b, need 1 0 0",
                                   ops[t], adrs[t], addr_err, stall, mem_req); end
      idleCycle();
      checks++;
      if (addr_err !== 1'b0)
        begin failures++; $display("FAIL misalign_pulse: aerr=%b, need 0", addr_err); end
    end
  endtask

  task automatic test_timeout();
    int reqCyc;
    bit dropped;
    reqCyc = 0;
    dropped = 0;
    @(negedge clk);
    OPCODE = OP_LW; MemRead = 1'b1; MemWrite = 1'b0; addr = 32'h108; mem_ack = 1'b0;
    for (int c = 0; c < 20 && !dropped; c++) begin
      @(negedge clk);
      #1;
      if (mem_req === 1'b1) reqCyc++;
      else begin
        dropped = 1;
`ifdef DMEM_SEQ_TIMEOUT_EN
        checks++;
        if (bus_err !== 1'b1 || rdata_valid !== 1'b0 || stall !== 1'b0)
          begin failures++; $display("FAIL timeout_done: berr=%b rv=%b stall=%b, need 1 0 0",
                                     bus_err, rdata_valid, stall); end
`endif
      end
`ifndef DMEM_SEQ_TIMEOUT_EN
      checks++;
      if (bus_err !== 1'b0)
        begin failures++; $display("FAIL no_watchdog_berr: berr=%b, need 0", bus_err); end
`endif
    end
`ifdef DMEM_SEQ_TIMEOUT_EN
    checks++;
    if (!dropped || reqCyc != 8)
      begin failures++; $display("FAIL timeout_len: req_cycles=%0d dropped=%0d, need 8 1", reqCyc, dropped); end
    idleCycle();
    checks++;
    if (bus_err !== 1'b0)
      begin failures++; $display("FAIL timeout_pulse: berr=%b, need 0", bus_err); end
`else
    checks++;
    if (dropped || reqCyc != 20)
      begin failures++; $display("FAIL no_watchdog_wait: req_cycles=%0d, need 20", reqCyc); end
    rst = 1'b1; MemRead = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    lastRdata = 32'h0;
    idleCycle();
`endif
  endtask

  task automatic test_back_to_back_random();
    logic [5:0] ops [12];
    logic [5:0] op;
    logic [1:0] k;
    int sc;
    logic [3:0] be;
    logic [31:0] wd;
    ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR,
            OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR};
    for (int i = 0; i < 8; i++) memW[i] = $urandom;
    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(0, 11)];
      k  = 2'($urandom_range(0, 3));
      if (op == OP_LW || op == OP_SW) k = 2'd0;
      if (op == OP_LH || op == OP_LHU || op == OP_SH) k[0] = 1'b0;
      runOp(op, {27'h8, 3'($urandom_range(0, 7)), k}, $urandom, $urandom_range(0, 3), sc, be, wd);
    end
    idleCycle();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_wait();
    test_reset_mid_req();
    test_misaligned();
    test_timeout();
    test_back_to_back_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
